// File: rtl/tamara_vote_pkg.sv
// tamara_vote_pkg: shared FSM state type and replica index constants for the TMR vote monitor.
package tamara_vote_pkg;
    typedef enum logic [1:0] {
        ST_MONITOR = 2'd0,
        ST_RESYNC  = 2'd1,
        ST_SETTLE  = 2'd2
    } state_t;
    localparam int REP_A = 0;
    localparam int REP_B = 1;
    localparam int REP_C = 2;
endpackage

// File: rtl/tamara_majority_voter.sv
// tamara_majority_voter: combinational bitwise 2-of-3 vote, per-replica disagreement and
// detection of the case where no two replicas agree as whole words.
module tamara_majority_voter
    import tamara_vote_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_c,
    output logic [WIDTH-1:0] o_voted,
    output logic [2:0]       o_mismatch,
    output logic             o_uncorrectable
);
    assign o_voted             = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
    assign o_mismatch[REP_A]   = i_a != o_voted;
    assign o_mismatch[REP_B]   = i_b != o_voted;
    assign o_mismatch[REP_C]   = i_c != o_voted;
    assign o_uncorrectable     = (i_a != i_b) && (i_a != i_c) && (i_b != i_c);
endmodule

// File: rtl/tmr_vote_monitor.sv
// tmr_vote_monitor: registered TMR vote with persistence-filtered sticky fault flags,
// saturating error counter and a MONITOR/RESYNC/SETTLE resynchronisation handshake.
module tmr_vote_monitor
    import tamara_vote_pkg::*;
#(
    parameter int WIDTH   = 2,
    parameter int PERSIST = 3,
    parameter int SETTLE  = 4,
    parameter int ERR_W   = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_c,
    input  logic             i_clr_fault,
    input  logic             i_resync_ack,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_voted,
    output logic [2:0]       o_mismatch,
    output logic [2:0]       o_fault,
    output logic             o_uncorrectable,
    output logic [ERR_W-1:0] o_err_count,
    output logic             o_resync_req
);
    localparam int PW = 4;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] w_voted, r_voted;
    logic [2:0]       w_mis, r_mis, w_set, r_fault, r_fault_d;
    logic             w_unc, r_unc, r_valid, r_resync, w_mon, w_trig;
    logic [PW-1:0]    r_pcnt [3];
    logic [7:0]       r_scnt;
    logic [ERR_W-1:0] r_err;

    tamara_majority_voter #(.WIDTH(WIDTH)) u_voter (
        .i_a             (i_a),
        .i_b             (i_b),
        .i_c             (i_c),
        .o_voted         (w_voted),
        .o_mismatch      (w_mis),
        .o_uncorrectable (w_unc)
    );

    assign w_mon = r_state == ST_MONITOR;

    // a fault is set on the mismatching cycle that brings the counter to PERSIST
    for (genvar k = 0; k < 3; k++) begin : g_set
        assign w_set[k] = w_mon && i_valid && w_mis[k] && (r_pcnt[k] >= PW'(PERSIST - 1));
    end

    assign w_trig = w_mon && ((|(r_fault & ~r_fault_d)) || (i_valid && w_unc));

    always_comb begin
        w_state_nxt = r_state;
        if (w_trig)
            w_state_nxt = ST_RESYNC;
        else if (r_state == ST_RESYNC && i_resync_ack)
            w_state_nxt = ST_SETTLE;
        else if (r_state == ST_SETTLE && r_scnt == 8'(SETTLE - 1))
            w_state_nxt = ST_MONITOR;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_MONITOR;
            r_scnt   <= '0;
            r_resync <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_scnt   <= (r_state == ST_SETTLE) ? r_scnt + 8'd1 : 8'd0;
            r_resync <= w_state_nxt == ST_RESYNC;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_voted   <= '0;
            r_valid   <= 1'b0;
            r_mis     <= '0;
            r_unc     <= 1'b0;
            r_fault   <= '0;
            r_fault_d <= '0;
            r_err     <= '0;
            for (int k = 0; k < 3; k++) r_pcnt[k] <= '0;
        end else begin
            r_voted   <= i_valid ? w_voted : r_voted;
            r_valid   <= i_valid;
            r_mis     <= i_valid ? w_mis : 3'b000;
            r_unc     <= i_valid && w_unc;
            r_fault   <= (i_clr_fault ? 3'b000 : r_fault) | w_set;
            r_fault_d <= r_fault;
            r_err     <= i_clr_fault ? '0 :
                         (i_valid && (|w_mis) && r_err != '1) ? r_err + ERR_W'(1) : r_err;
            for (int k = 0; k < 3; k++)
                r_pcnt[k] <= (!w_mon || i_clr_fault) ? '0 :
                             !i_valid ? r_pcnt[k] :
                             !w_mis[k] ? '0 :
                             (r_pcnt[k] == PW'(PERSIST)) ? r_pcnt[k] : r_pcnt[k] + PW'(1);
        end
    end

    assign o_valid         = r_valid;
    assign o_voted         = r_voted;
    assign o_mismatch      = r_mis;
    assign o_fault         = r_fault;
    assign o_uncorrectable = r_unc;
    assign o_err_count     = r_err;
    assign o_resync_req    = r_resync;
endmodule

// File: tb/tb_tmr_vote_monitor.sv
// tb_tmr_vote_monitor: directed scenario tasks with hand-computed expectations for tmr_vote_monitor.
module tb_tmr_vote_monitor;
    import tamara_vote_pkg::*;

    logic       i_clk = 1'b0, i_rst_n = 1'b0, i_valid = 1'b0, i_clr_fault = 1'b0, i_resync_ack = 1'b0;
    logic [1:0] i_a = '0, i_b = '0, i_c = '0;
    logic       o_valid, o_uncorrectable, o_resync_req;
    logic [1:0] o_voted;
    logic [2:0] o_mismatch, o_fault;
    logic [7:0] o_err_count;
    int checks = 0, errors = 0;

    always #5 i_clk = ~i_clk;

    tmr_vote_monitor #(.WIDTH(2), .PERSIST(3), .SETTLE(4), .ERR_W(8)) dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_valid         (i_valid),
        .i_a             (i_a),
        .i_b             (i_b),
        .i_c             (i_c),
        .i_clr_fault     (i_clr_fault),
        .i_resync_ack    (i_resync_ack),
        .o_valid         (o_valid),
        .o_voted         (o_voted),
        .o_mismatch      (o_mismatch),
        .o_fault         (o_fault),
        .o_uncorrectable (o_uncorrectable),
        .o_err_count     (o_err_count),
        .o_resync_req    (o_resync_req)
    );

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
        i_valid = v;
        i_a     = a;
        i_b     = b;
        i_c     = c;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b exp 0", o_valid); end
        checks++; if (o_voted !== 2'b00) begin errors++; $display("FAIL rst_voted: got %b exp 00", o_voted); end
        checks++; if (o_mismatch !== 3'b000) begin errors++; $display("FAIL rst_mismatch: got %b exp 000", o_mismatch); end
        checks++; if (o_fault !== 3'b000) begin errors++; $display("FAIL rst_fault: got %b exp 000", o_fault); end
        checks++; if (o_uncorrectable !== 1'b0) begin errors++; $display("FAIL rst_unc: got %b exp 0", o_uncorrectable); end
        checks++; if (o_err_count !== 8'd0) begin errors++; $display("FAIL rst_err: got %0d exp 0", o_err_count); end
        checks++; if (o_resync_req !== 1'b0) begin errors++; $display("FAIL rst_resync: got %b exp 0", o_resync_req); end
        tick();
        i_rst_n = 1'b1;
    endtask

    task automatic test_agree();
        drive(1'b1, 2'b10, 2'b10, 2'b10);
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (o_voted !== 2'b10) begin errors++; $display("FAIL agree_voted[%0d]: got %b exp 10", i, o_voted); end
            checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL agree_valid[%0d]: got %b exp 1", i, o_valid); end
            checks++; if (o_mismatch !== 3'b000) begin errors++; $display("FAIL agree_mis[%0d]: got %b exp 000", i, o_mismatch); end
            checks++; if (o_err_count !== 8'd0) begin errors++; $display("FAIL agree_err[%0d]: got %0d exp 0", i, o_err_count); end
            checks++; if (o_fault !== 3'b000) begin errors++; $display("FAIL agree_fault[%0d]: got %b exp 000", i, o_fault); end
        end
        drive(1'b0, 2'b01, 2'b01, 2'b01);
        tick();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL hold_valid: got %b exp 0", o_valid); end
        checks++; if (o_voted !== 2'b10) begin errors++; $display("FAIL hold_voted: got %b exp 10", o_voted); end
        checks++; if (o_mismatch !== 3'b000) begin errors++; $display("FAIL hold_mis: got %b exp 000", o_mismatch); end
    endtask

    task automatic test_single_fault();
        drive(1'b1, 2'b01, 2'b11, 2'b11);
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++; if (o_voted !== 2'b11) begin errors++; $display("FAIL sf_voted[%0d]: got %b exp 11", i, o_voted); end
            checks++; if (o_mismatch !== 3'b001) begin errors++; $display("FAIL sf_mis[%0d]: got %b exp 001", i, o_mismatch); end
            checks++; if (o_err_count !== 8'(i)) begin errors++; $display("FAIL sf_err[%0d]: got %0d exp %0d", i, o_err_count, i); end
            checks++; if (o_fault !== ((i == 3) ? 3'b001 : 3'b000)) begin errors++; $display("FAIL sf_fault[%0d]: got %b exp %b", i, o_fault, (i == 3) ? 3'b001 : 3'b000); end
            checks++; if (o_resync_req !== 1'b0) begin errors++; $display("FAIL sf_resync[%0d]: got %b exp 0", i, o_resync_req); end
        end
        drive(1'b0, 2'b01, 2'b11, 2'b11);
        tick();
        checks++; if (o_resync_req !== 1'b1) begin errors++; $display("FAIL sf_resync_req: got %b exp 1", o_resync_req); end
        checks++; if (o_fault !== 3'b001) begin errors++; $display("FAIL sf_fault_hold: got %b exp 001", o_fault); end
        checks++; if (o_err_count !== 8'd3) begin errors++; $display("FAIL sf_err_hold: got %0d exp 3", o_err_count); end
        checks++; if (o_mismatch !== 3'b000) begin errors++; $display("FAIL sf_mis_invalid: got %b exp 000", o_mismatch); end
    endtask

    task automatic test_resync_settle();
        tick();
        checks++; if (o_resync_req !== 1'b1) begin errors++; $display("FAIL rs_wait: got %b exp 1", o_resync_req); end
        drive(1'b1, 2'b00, 2'b01, 2'b00);
        i_resync_ack = 1'b1;
        tick();
        i_resync_ack = 1'b0;
        checks++; if (o_resync_req !== 1'b0) begin errors++; $display("FAIL rs_ack_drop: got %b exp 0", o_resync_req); end
        checks++; if (o_mismatch !== 3'b010) begin errors++; $display("FAIL rs_mis: got %b exp 010", o_mismatch); end
        checks++; if (o_err_count !== 8'd4) begin errors++; $display("FAIL rs_err: got %0d exp 4", o_err_count); end
        for (int i = 1; i <= 4; i++) begin
            if (i == 2) i_resync_ack = 1'b1;
            tick();
            i_resync_ack = 1'b0;
            checks++; if (o_fault !== 3'b001) begin errors++; $display("FAIL settle_fault[%0d]: got %b exp 001", i, o_fault); end
            checks++; if (o_resync_req !== 1'b0) begin errors++; $display("FAIL settle_resync[%0d]: got %b exp 0", i, o_resync_req); end
            checks++; if (o_err_count !== 8'(4 + i)) begin errors++; $display("FAIL settle_err[%0d]: got %0d exp %0d", i, o_err_count, 4 + i); end
            checks++; if (dut.r_state !== ((i == 4) ? ST_MONITOR : ST_SETTLE)) begin errors++; $display("FAIL settle_state[%0d]: got %0d exp %0d", i, dut.r_state, (i == 4) ? ST_MONITOR : ST_SETTLE); end
        end
        for (int i = 5; i <= 7; i++) begin
            tick();
            checks++; if (o_fault !== ((i == 7) ? 3'b011 : 3'b001)) begin errors++; $display("FAIL mon_fault_b[%0d]: got %b exp %b", i, o_fault, (i == 7) ? 3'b011 : 3'b001); end
        end
        tick();
        checks++; if (o_resync_req !== 1'b1) begin errors++; $display("FAIL mon_resync_b: got %b exp 1", o_resync_req); end
        checks++; if (o_err_count !== 8'd12) begin errors++; $display("FAIL mon_err_b: got %0d exp 12", o_err_count); end
    endtask

    task automatic test_uncorrectable();
        drive(1'b1, 2'b00, 2'b00, 2'b00);
        i_resync_ack = 1'b1;
        tick();
        i_resync_ack = 1'b0;
        repeat (4) tick();
        checks++; if (dut.r_state !== ST_MONITOR) begin errors++; $display("FAIL unc_pre_state: got %0d exp %0d", dut.r_state, ST_MONITOR); end
        checks++; if (o_resync_req !== 1'b0) begin errors++; $display("FAIL unc_pre_resync: got %b exp 0", o_resync_req); end
        drive(1'b1, 2'b00, 2'b01, 2'b10);
        tick();
        checks++; if (o_voted !== 2'b00) begin errors++; $display("FAIL unc_voted: got %b exp 00", o_voted); end
        checks++; if (o_uncorrectable !== 1'b1) begin errors++; $display("FAIL unc_pulse: got %b exp 1", o_uncorrectable); end
        checks++; if (o_mismatch !== 3'b110) begin errors++; $display("FAIL unc_mis: got %b exp 110", o_mismatch); end
        checks++; if (o_resync_req !== 1'b1) begin errors++; $display("FAIL unc_resync: got %b exp 1", o_resync_req); end
        checks++; if (o_err_count !== 8'd13) begin errors++; $display("FAIL unc_err: got %0d exp 13", o_err_count); end
        drive(1'b0, 2'b00, 2'b01, 2'b10);
        tick();
        checks++; if (o_uncorrectable !== 1'b0) begin errors++; $display("FAIL unc_pulse_end: got %b exp 0", o_uncorrectable); end
        checks++; if (o_resync_req !== 1'b1) begin errors++; $display("FAIL unc_resync_hold: got %b exp 1", o_resync_req); end
    endtask

    task automatic test_saturation();
        drive(1'b1, 2'b01, 2'b11, 2'b11);
        repeat (300) tick();
        checks++; if (o_err_count !== 8'd255) begin errors++; $display("FAIL sat_err: got %0d exp 255", o_err_count); end
        checks++; if (o_fault !== 3'b011) begin errors++; $display("FAIL sat_no_new_fault: got %b exp 011", o_fault); end
        checks++; if (o_mismatch !== 3'b001) begin errors++; $display("FAIL sat_mis: got %b exp 001", o_mismatch); end
        checks++; if (o_resync_req !== 1'b1) begin errors++; $display("FAIL sat_resync: got %b exp 1", o_resync_req); end
        tick();
        checks++; if (o_err_count !== 8'd255) begin errors++; $display("FAIL sat_no_wrap: got %0d exp 255", o_err_count); end
        drive(1'b0, 2'b01, 2'b11, 2'b11);
        i_clr_fault = 1'b1;
        tick();
        i_clr_fault = 1'b0;
        checks++; if (o_err_count !== 8'd0) begin errors++; $display("FAIL clr_err: got %0d exp 0", o_err_count); end
        checks++; if (o_fault !== 3'b000) begin errors++; $display("FAIL clr_fault: got %b exp 000", o_fault); end
        checks++; if (o_resync_req !== 1'b1) begin errors++; $display("FAIL clr_fsm_kept: got %b exp 1", o_resync_req); end
    endtask

    task automatic test_reset_mid_resync();
        drive(1'b1, 2'b11, 2'b11, 2'b11);
        tick();
        checks++; if (o_voted !== 2'b11) begin errors++; $display("FAIL pre_rst_voted: got %b exp 11", o_voted); end
        #2;
        i_rst_n = 1'b0;
        #1;
        checks++; if (o_voted !== 2'b00) begin errors++; $display("FAIL mid_rst_voted: got %b exp 00", o_voted); end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b exp 0", o_valid); end
        checks++; if (o_resync_req !== 1'b0) begin errors++; $display("FAIL mid_rst_resync: got %b exp 0", o_resync_req); end
        checks++; if (o_fault !== 3'b000) begin errors++; $display("FAIL mid_rst_fault: got %b exp 000", o_fault); end
        checks++; if (o_err_count !== 8'd0) begin errors++; $display("FAIL mid_rst_err: got %0d exp 0", o_err_count); end
        checks++; if (dut.r_state !== ST_MONITOR) begin errors++; $display("FAIL mid_rst_state: got %0d exp %0d", dut.r_state, ST_MONITOR); end
        tick();
        i_rst_n = 1'b1;
        tick();
        checks++; if (o_resync_req !== 1'b0) begin errors++; $display("FAIL post_rst_resync: got %b exp 0", o_resync_req); end
        checks++; if (o_voted !== 2'b11) begin errors++; $display("FAIL post_rst_voted: got %b exp 11", o_voted); end
    endtask

    initial begin
        test_reset();
        test_agree();
        test_single_fault();
        test_resync_settle();
        test_uncorrectable();
        test_saturation();
        test_reset_mid_resync();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
